// File: rtl/gp_register_file_if.sv
// Bus bundle for gp_register_file: write/read ports, block-transfer control,
// and the save/restore streams.
interface gp_register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] rd_addr_a;
  logic [DATA_WIDTH-1:0] rd_data_a;
  logic [ADDR_WIDTH-1:0] rd_addr_b;
  logic [DATA_WIDTH-1:0] rd_data_b;
  logic                  blk_start;
  logic                  blk_dir;
  logic [ADDR_WIDTH-1:0] blk_first;
  logic [ADDR_WIDTH-1:0] blk_last;
  logic                  blk_busy;
  logic                  blk_done;
  logic                  sv_valid;
  logic [DATA_WIDTH-1:0] sv_data;
  logic [ADDR_WIDTH-1:0] sv_index;
  logic                  sv_ready;
  logic                  rs_valid;
  logic [DATA_WIDTH-1:0] rs_data;
  logic                  rs_ready;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
           blk_start, blk_dir, blk_first, blk_last, sv_ready, rs_valid, rs_data,
    input  rd_data_a, rd_data_b, blk_busy, blk_done, sv_valid, sv_data,
           sv_index, rs_ready
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
           blk_start, blk_dir, blk_first, blk_last, sv_ready, rs_valid, rs_data,
    output rd_data_a, rd_data_b, blk_busy, blk_done, sv_valid, sv_data,
           sv_index, rs_ready
  );
endinterface

// File: rtl/gp_register_file.sv
// General-purpose register bank: two bypassed read ports, one write port and a
// save/restore block-transfer engine. Define R0_ZERO_EN to hardwire register 0 to zero.
module gp_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic               clock,
  input  logic               clear,
  gp_register_file_if.slave  bus
);

  localparam int                    IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH:0]   NREGS    = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] sv_data_q, sv_data_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < NREGS;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_idx(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST_IDX) ? '0 : a + 1'b1;
  endfunction

  // Read value including write-through of whichever write is active this cycle.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    if (in_range(a)) begin
      if (wen && (waddr == a)) r = wdata;
      else                     r = regs_q[a[IDX_W-1:0]];
    end
`ifdef R0_ZERO_EN
    if (a == '0) r = '0;
`endif
    return r;
  endfunction

  // The restore stream owns the write port while in RESTORE; external writes are dropped.
  always_comb begin
    wen   = bus.wr_en;
    waddr = bus.wr_addr;
    wdata = bus.wr_data;
    if (state_q == RESTORE) begin
      wen   = bus.rs_valid;
      waddr = idx_q;
      wdata = bus.rs_data;
    end
    if (!in_range(waddr)) wen = 1'b0;
`ifdef R0_ZERO_EN
    if (waddr == '0) wen = 1'b0;
`endif
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wen) begin
      regs_q[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  always_comb begin
    bus.rd_data_a = read_port(bus.rd_addr_a);
    bus.rd_data_b = read_port(bus.rd_addr_b);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    sv_data_d = sv_data_q;
    case (state_q)
      IDLE: begin
        if (bus.blk_start && in_range(bus.blk_first) && in_range(bus.blk_last)) begin
          idx_d  = bus.blk_first;
          last_d = bus.blk_last;
          if (bus.blk_dir) begin
            state_d = RESTORE;
          end else begin
            state_d   = SAVE;
            sv_data_d = read_port(bus.blk_first);
          end
        end
      end
      SAVE: begin
        // Capturing the next word on the handshake edge keeps the stream bubble-free.
        if (bus.sv_ready) begin
          if (idx_q == last_q) begin
            state_d = DONE;
          end else begin
            idx_d     = next_idx(idx_q);
            sv_data_d = read_port(next_idx(idx_q));
          end
        end
      end
      RESTORE: begin
        if (bus.rs_valid) begin
          if (idx_q == last_q) state_d = DONE;
          else                 idx_d   = next_idx(idx_q);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      sv_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      sv_data_q <= sv_data_d;
    end
  end

  assign bus.blk_busy = (state_q == SAVE) || (state_q == RESTORE);
  assign bus.blk_done = (state_q == DONE);
  assign bus.sv_valid = (state_q == SAVE);
  assign bus.rs_ready = (state_q == RESTORE);
  assign bus.sv_data  = sv_data_q;
  assign bus.sv_index = idx_q;

endmodule
